// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among N_CORES cores.
// One grant per cycle; losing requesters are stalled. Read data returns to
// the granted core as a registered response one cycle after the grant.
module mem_arbiter #(
  parameter  int N_CORES   = 2,
  parameter  int MEM_WIDTH = 32,
  parameter  int MEM_SIZE  = 256,
  localparam int AW        = $clog2(MEM_SIZE),
  localparam int CW        = $clog2(N_CORES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CORES*AW-1:0]    req_addr,
  input  logic [N_CORES-1:0]       req_read_en,
  input  logic [N_CORES-1:0]       req_write_en,
  input  logic [N_CORES*MEM_WIDTH-1:0] req_write_val,
  output logic [N_CORES-1:0]       stall,
  output logic [N_CORES-1:0]       rsp_valid,
  output logic [MEM_WIDTH-1:0]     rsp_data,
  output logic [AW-1:0]            mem_addr,
  output logic                     mem_read_en,
  output logic                     mem_write_en,
  output logic [MEM_WIDTH-1:0]     mem_write_val,
  input  logic [MEM_WIDTH-1:0]     mem_read_val,
  output logic [CW-1:0]            token
);

  logic [CW-1:0]        r_token;
  logic [N_CORES-1:0]   r_rsp_valid;
  logic [MEM_WIDTH-1:0] r_rsp_data;

  logic [N_CORES-1:0]   w_req;
  logic                 w_found;
  logic                 w_grant_any;
  logic [CW-1:0]        w_grant_idx;
  logic [N_CORES-1:0]   w_grant_onehot;
  logic [CW-1:0]        w_next_token;

  // Index k positions above base, wrapping at N_CORES (sum is always < 2*N_CORES).
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_CORES) sum = sum - N_CORES;
    return CW'(sum);
  endfunction

  // Grant search: first requester at or above the token, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    w_req          = req_read_en | req_write_en;
    w_found        = 1'b0;
    w_grant_idx    = '0;
    w_grant_onehot = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (!w_found && w_req[wrap_idx(r_token, k)]) begin
        w_found     = 1'b1;
        w_grant_idx = wrap_idx(r_token, k);
      end
    end
    // Reset suppresses the grant, so nothing reaches memory while it is held.
    w_grant_any = w_found & reset;
    if (w_grant_any) w_grant_onehot[w_grant_idx] = 1'b1;
    w_next_token = (w_grant_idx == CW'(N_CORES - 1)) ? '0 : w_grant_idx + 1'b1;
  end

  // Memory-port mux and stall generation from the one-hot grant.
  always_comb begin
    mem_addr      = '0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_write_val = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (w_grant_onehot[i]) begin
        mem_addr      = req_addr[i*AW +: AW];
        mem_write_val = req_write_val[i*MEM_WIDTH +: MEM_WIDTH];
        mem_write_en  = req_write_en[i];
        mem_read_en   = req_read_en[i] & ~req_write_en[i];
      end
    end
    stall = reset ? (w_req & ~w_grant_onehot) : '0;
  end

  // Token rotation and registered read response.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) begin
      r_token     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_grant_any) r_token <= w_next_token;
      r_rsp_valid <= mem_read_en ? w_grant_onehot : '0;
      if (mem_read_en) r_rsp_data <= mem_read_val;
    end
  end

  assign token     = r_token;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
